// File: rtl/bypass_controller_pkg.sv
// bypass_controller_pkg: shared register-number constants and pipeline hazard types
package BasicTypes;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

package PipelineTypes;

    import BasicTypes::*;

    typedef enum logic [1:0] {
        BYPASS_NONE = 2'd0,
        BYPASS_EXEC = 2'd1,
        BYPASS_MEM  = 2'd2
    } BypassCtrl;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  writeReg;
        logic                  isLoad;
    } HazardSlot;

    // A slot only produces a value worth waiting for when it really writes a non-zero register
    function automatic logic is_producer(input HazardSlot s, input logic [REG_ADDR_W-1:0] addr);
        return s.valid && s.writeReg && (s.rd != REG_ZERO) && (s.rd == addr);
    endfunction

endpackage

// File: rtl/bypass_controller_select.sv
// bypass_select: per-operand forwarding select and hazard detection (RISKY2_BYPASS_EN enables forwarding)
module bypass_select
    import BasicTypes::*;
    import PipelineTypes::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  used,
    input  HazardSlot             ex,
    input  HazardSlot             mem,
    input  HazardSlot             wb,
    output BypassCtrl             sel,
    output logic                  hazard
);

    logic active;
    logic ex_hit;
    logic mem_hit;
    logic unused_bits;

    assign active      = used && (addr != REG_ZERO);
    assign ex_hit      = active && is_producer(ex, addr);
    assign mem_hit     = active && is_producer(mem, addr);
    assign unused_bits = ^{ex, mem, wb};

`ifdef RISKY2_BYPASS_EN
    // Youngest producer wins; a load still in EX has no data yet, so its consumer waits a cycle
    always_comb begin
        hazard = ex_hit && ex.isLoad;
        sel    = ex_hit ? BYPASS_EXEC : mem_hit ? BYPASS_MEM : BYPASS_NONE;
    end
`else
    logic wb_hit;

    assign wb_hit = active && is_producer(wb, addr);

    // Without forwarding the consumer waits until every in-flight producer has retired
    always_comb begin
        hazard = ex_hit || mem_hit || wb_hit;
        sel    = BYPASS_NONE;
    end
`endif

endmodule

// File: rtl/bypass_controller.sv
// bypass_controller: hazard tracking and registered forwarding selects; RISKY2_BYPASS_EN enables forwarding, else interlock only
module bypass_controller
    import BasicTypes::*;
    import PipelineTypes::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs1Addr,
    input  logic [REG_ADDR_W-1:0] idRs2Addr,
    input  logic                  idRs1Used,
    input  logic                  idRs2Used,
    input  logic [REG_ADDR_W-1:0] idRdAddr,
    input  logic                  idWriteReg,
    input  logic                  idIsLoad,
    output BypassCtrl             op1BypassCtrl,
    output BypassCtrl             op2BypassCtrl,
    output logic                  hazardStall
);

    HazardSlot exSlot;
    HazardSlot memSlot;
    HazardSlot wbSlot;
    HazardSlot idSlot;
    BypassCtrl sel1;
    BypassCtrl sel2;
    logic      haz1;
    logic      haz2;
    logic      issue;

    bypass_select u_op1 (
        .addr   (idRs1Addr),
        .used   (idRs1Used),
        .ex     (exSlot),
        .mem    (memSlot),
        .wb     (wbSlot),
        .sel    (sel1),
        .hazard (haz1)
    );

    bypass_select u_op2 (
        .addr   (idRs2Addr),
        .used   (idRs2Used),
        .ex     (exSlot),
        .mem    (memSlot),
        .wb     (wbSlot),
        .sel    (sel2),
        .hazard (haz2)
    );

    assign hazardStall = idValid && !flush && (haz1 || haz2);
    assign issue       = idValid && !flush && !hazardStall;
    assign idSlot      = '{valid: 1'b1, rd: idRdAddr, writeReg: idWriteReg, isLoad: idIsLoad};

    // Advance the in-flight slots and latch the selects for whatever enters EX; a bubble gets no forwarding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exSlot        <= '0;
            memSlot       <= '0;
            wbSlot        <= '0;
            op1BypassCtrl <= BYPASS_NONE;
            op2BypassCtrl <= BYPASS_NONE;
        end else if (!stall) begin
            wbSlot        <= memSlot;
            memSlot       <= exSlot;
            exSlot        <= issue ? idSlot : '0;
            op1BypassCtrl <= issue ? sel1 : BYPASS_NONE;
            op2BypassCtrl <= issue ? sel2 : BYPASS_NONE;
        end
    end

endmodule

// File: doc/bypass_controller.md
# bypass_controller

Hazard-tracking and forwarding-select generator for the five-stage integer pipeline, sitting between decode and execute. It records the destination register of every instruction in flight in EX, MEM and WB. For the instruction leaving ID it issues registered `op1BypassCtrl`/`op2BypassCtrl` selects, which the operand switcher consumes during that instruction's EX cycle. It also raises a combinational `hazardStall` for load-use and interlock hazards, and inserts the bubble that the stall implies.

## Interface
- No parameters; register address width fixed at 5 bits (x0–x31).
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: global pipeline freeze (memory wait); all internal state holds.
- `flush` in 1: squash the instruction currently in ID (branch redirect); older slots unaffected.
- `idValid` in 1: ID holds a real instruction.
- `idRs1Addr`, `idRs2Addr` in 5 each: source register numbers.
- `idRs1Used`, `idRs2Used` in 1 each: operand actually read from the register file.
- `idRdAddr` in 5: destination register.
- `idWriteReg` in 1: instruction writes `idRdAddr`.
- `idIsLoad` in 1: instruction is a load.
- `op1BypassCtrl`, `op2BypassCtrl` out BypassCtrl: registered selects for the instruction in EX.
- `hazardStall` out 1: combinational; holds PC and the IF/ID register this cycle.

## Operation
- Internal slots `exSlot`, `memSlot`, `wbSlot` each hold {valid, rd, writeReg, isLoad}.
- A slot counts as a producer only if valid, writeReg is set, and rd ≠ 0.
- Advance condition: `adv = !stall`.
  - On `adv`, `wbSlot ← memSlot` and `memSlot ← exSlot`.
  - `exSlot` receives the ID instruction if `idValid && !flush && !hazardStall`, otherwise a bubble (valid=0).
- Per operand (operand counts as used only if rsN used and rsN ≠ 0), forwarding build:
  - If a producer in `exSlot` matches rsN and is a load, `hazardStall` is asserted.
  - Else if a producer in `exSlot` matches, the next select is `BYPASS_EXEC`.
  - Else if a producer in `memSlot` matches, the next select is `BYPASS_MEM`.
  - Else the next select is `BYPASS_NONE`.
  - EX match takes priority over MEM match (youngest producer wins).
  - `wbSlot` is never a forwarding source; the register file writes in the first half-cycle.
- `hazardStall` is the OR over both operands, gated by `idValid && !flush`.
- Select registers load on `adv`:
  - The computed value if the ID instruction enters EX.
  - `BYPASS_NONE` if a bubble enters EX.

## Timing
- Reset values:
  - All slots invalid, with rd=0, writeReg=0, isLoad=0.
  - Both selects `BYPASS_NONE`.
  - `hazardStall`=0 (no valid slot).
- Select latency: computed in the consumer's ID cycle, valid for the entire following EX cycle.
- Load-use costs exactly 1 stall cycle. After the bubble the load sits in `memSlot`, so the consumer gets `BYPASS_MEM`.
- `stall` dominates `hazardStall`:
  - While `stall`=1, slots and selects hold.
  - `hazardStall` is still driven combinationally from the held state.
- `flush` together with `hazardStall`: `flush` wins. The bubble is inserted and `hazardStall` is forced to 0.
- `rst` mid-operation clears all state immediately, with no clock edge required.

## Configuration
- Controlled by the macro `RISKY2_BYPASS_EN`.
- With `RISKY2_BYPASS_EN` defined: full forwarding as above.
- Without it: pure interlock mode.
  - Selects are constant `BYPASS_NONE`.
  - `hazardStall` asserts whenever any producer in `exSlot`, `memSlot` or `wbSlot` matches a used source.
  - A back-to-back dependency therefore stalls 3 cycles.

## Structure
- `BypassCtrl` (`BYPASS_NONE`/`BYPASS_EXEC`/`BYPASS_MEM`) remains in `PipelineTypes`.
- Add a `HazardSlot` struct {valid, rd[4:0], writeReg, isLoad} to `PipelineTypes`.
- Add the `REG_ZERO` constant (5'd0) to `BasicTypes`.
- One combinational sub-module, `bypass_select`.
  - Inputs: one source address and used flag, plus the three slots.
  - Outputs: next select and hazard flag.
  - Instantiated once per operand.

## Test plan
- Reset-state check: assert `rst` mid-run → all outputs immediately `BYPASS_NONE` and `hazardStall`=0; the first dependent instruction after reset gets no forwarding.
- EX forwarding: ALU `add x5` then `sub` reading rs1=x5 → `op1BypassCtrl`=`BYPASS_EXEC` in the sub's EX cycle, `op2BypassCtrl`=`BYPASS_NONE`, no stall.
- MEM forwarding: `add x5`, an independent instruction, then a reader of rs2=x5 → `op2BypassCtrl`=`BYPASS_MEM`.
- Priority: `addi x5`, `addi x5`, then a reader of x5 → `BYPASS_EXEC`, since the youngest producer wins.
- Load-use:
  - `lw x7`, then `add` reading x7 → `hazardStall`=1 for exactly 1 cycle, then `BYPASS_MEM`.
  - `flush` in the stall cycle → bubble, `hazardStall`=0.
- x0 and interlock mode:
  - A writer to x0 followed by a reader of x0 → `BYPASS_NONE`, no stall.
  - Without `RISKY2_BYPASS_EN`, back-to-back dependent adds → `hazardStall` high 3 cycles, selects stay `BYPASS_NONE`.
